// File: rtl/op_sequencer_if.sv
// Dispatch bus between the operand sequencer and an external arithmetic unit.
// Handshake: master raises start for exactly one cycle with num1/num2/op stable;
// slave may raise done on that cycle or any later cycle, with res_in/of_in valid while done=1.
interface op_sequencer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic [1:0]       op;
  logic             start;
  logic             done;
  logic [WIDTH-1:0] res_in;
  logic             of_in;

  modport master (output num1, num2, op, start, input done, res_in, of_in);
  modport slave  (input num1, num2, op, start, output done, res_in, of_in);
endinterface

// File: rtl/op_sequencer.sv
// Button-driven operand entry and start/done dispatch to a multi-cycle arithmetic unit,
// with result latching, optional result chaining, clear and EXEC timeout.
module op_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255,
  parameter bit CHAIN   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic [3:0]       btn,
  input  logic             clr,
  op_sequencer_if.master   unit,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             err,
  output logic [2:0]       state,
  output logic             disp_en
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD1 = 3'd1,
    S_LOAD2 = 3'd2,
    S_EXEC  = 3'd3,
    S_SHOW  = 3'd4
  } state_e;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] num1_q, num1_d;
  logic [WIDTH-1:0] num2_q, num2_d;
  logic [1:0]       op_q, op_d;
  logic             start_q, start_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             overflow_q, overflow_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             btn_ev;
  logic [1:0]       btn_code;

  assign btn_ev = |btn;

  // Lowest set button index selects the opcode.
  always_comb begin
    btn_code = 2'd3;
    if (btn[0])      btn_code = 2'd0;
    else if (btn[1]) btn_code = 2'd1;
    else if (btn[2]) btn_code = 2'd2;
  end

  always_comb begin
    state_d    = state_q;
    num1_d     = num1_q;
    num2_d     = num2_q;
    op_d       = op_q;
    start_d    = 1'b0;
    result_d   = result_q;
    overflow_d = overflow_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    if (clr) begin
      state_d    = S_IDLE;
      num1_d     = '0;
      num2_d     = '0;
      result_d   = '0;
      overflow_d = 1'b0;
      err_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE:  if (btn_ev) state_d = S_LOAD1;
        S_LOAD1: begin
          num1_d = sw;
          if (btn_ev) state_d = S_LOAD2;
        end
        S_LOAD2: begin
          num2_d = sw;
          if (btn_ev) begin
            state_d = S_EXEC;
            op_d    = btn_code;
            start_d = 1'b1;
            cnt_d   = '0;
          end
        end
        S_EXEC: begin
          // done is checked before the timeout so a last-cycle done still wins.
          if (unit.done) begin
            result_d   = unit.res_in;
            overflow_d = unit.of_in;
            err_d      = 1'b0;
            state_d    = S_SHOW;
          end else if (cnt_q == CNT_LAST) begin
            result_d   = '0;
            overflow_d = 1'b0;
            err_d      = 1'b1;
            state_d    = S_SHOW;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_SHOW: begin
          if (CHAIN && btn_ev) begin
            num1_d     = result_q;
            overflow_d = 1'b0;
            err_d      = 1'b0;
            state_d    = S_LOAD2;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      num1_q     <= '0;
      num2_q     <= '0;
      op_q       <= 2'b00;
      start_q    <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      num1_q     <= num1_d;
      num2_q     <= num2_d;
      op_q       <= op_d;
      start_q    <= start_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign unit.num1  = num1_q;
  assign unit.num2  = num2_q;
  assign unit.op    = op_q;
  assign unit.start = start_q;
  assign result     = result_q;
  assign overflow   = overflow_q;
  assign err        = err_q;
  assign state      = state_q;
  assign disp_en    = (state_q == S_SHOW);

endmodule
